// File: rtl/div_unit_pkg.sv
// Shared definitions for the divide unit: data width, step count and FSM states.
package div_unit_pkg;

  localparam int DW = 32;
  localparam int CW = 6;

  // The counter starts at 0 on acceptance, so the 32nd step happens while it reads 31.
  localparam logic [CW-1:0] LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_unit_if.sv
// Controller-to-divider handshake: start pulses and operands in, status and results out.
interface div_unit_if;
  import div_unit_pkg::*;

  logic          div_start;
  logic          divu_start;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;

  // The controller side issues requests and watches status.
  modport master (
    output div_start, divu_start, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  // The divider side consumes requests and reports results.
  modport slave (
    input  div_start, divu_start, dividend, divisor,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/div_unit.sv
// Iterative 32-step restoring divider with signed/unsigned modes.
// Signed operands are reduced to magnitudes up front and the signs are
// re-applied in a single correction cycle once the magnitude divide is done.
module div_unit
  import div_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_rem;
  logic [DW-1:0] r_quo;
  logic [DW-1:0] r_divisor;
  logic          r_signA;
  logic          r_signB;
  logic [DW-1:0] r_quotient;
  logic [DW-1:0] r_remainder;

  logic          w_accept;
  logic          w_isSigned;
  logic [DW-1:0] w_absA;
  logic [DW-1:0] w_absB;
  logic [DW:0]   w_shift;
  logic [DW:0]   w_trial;
  logic [DW-1:0] w_quoFixed;
  logic [DW-1:0] w_remFixed;

  // A signed request wins when both start lines are raised together.
  assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                      (bus.div_start || bus.divu_start);
  assign w_isSigned = bus.div_start;
  assign w_absA     = (w_isSigned && bus.dividend[DW-1]) ? -bus.dividend : bus.dividend;
  assign w_absB     = (w_isSigned && bus.divisor[DW-1])  ? -bus.divisor  : bus.divisor;

  // One restoring step: shift in the next dividend bit, then trial-subtract.
  assign w_shift    = {r_rem, r_quo[DW-1]};
  assign w_trial    = w_shift - {1'b0, r_divisor};

  // Sign correction: quotient negative when signs differ, remainder follows the dividend.
  assign w_quoFixed = (r_signA ^ r_signB) ? -r_quo : r_quo;
  assign w_remFixed = r_signA ? -r_rem : r_rem;

  assign bus.busy      = (r_state == S_RUN) || (r_state == S_FIX);
  assign bus.done      = (r_state == S_DONE);
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: starts are only honoured from IDLE or DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nextState = S_RUN;
      S_RUN:   if (r_count >= LAST_STEP) w_nextState = S_FIX;
      S_FIX:   w_nextState = S_DONE;
      S_DONE:  w_nextState = w_accept ? S_RUN : S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result latch in the fix cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_signA     <= 1'b0;
      r_signB     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (w_accept) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= w_absA;
      r_divisor <= w_absB;
      r_signA   <= w_isSigned & bus.dividend[DW-1];
      r_signB   <= w_isSigned & bus.divisor[DW-1];
    end else if (r_state == S_RUN) begin
      if (!w_trial[DW]) begin
        r_rem <= w_trial[DW-1:0];
        r_quo <= {r_quo[DW-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[DW-1:0];
        r_quo <= {r_quo[DW-2:0], 1'b0};
      end
      if (r_count < LAST_STEP) begin
        r_count <= r_count + 6'd1;
      end
    end else if (r_state == S_FIX) begin
      r_quotient  <= w_quoFixed;
      r_remainder <= w_remFixed;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   nCycles;
  logic [31:0] expQ;
  logic [31:0] expR;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference divide from the arithmetic definition, wide enough to avoid overflow.
  function automatic void refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!sgn) begin
      if (b == 32'd0) begin
        q = 32'hFFFF_FFFF;
        r = a;
      end else begin
        q = a / b;
        r = a % b;
      end
    end else begin
      if (b == 32'd0) begin
        q = (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
        r = a;
      end else begin
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse the start lines for one accepting edge; operands are scrambled afterwards.
  task automatic applyStimulus(input bit s, input bit u, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.div_start  = s;
    bus.divu_start = u;
    bus.dividend   = a;
    bus.divisor    = b;
    @(posedge clk);
    #1;
    bus.div_start  = 1'b0;
    bus.divu_start = 1'b0;
    bus.dividend   = $urandom;
    bus.divisor    = $urandom;
  endtask

  // Count busy cycles until done, with a bounded wait.
  task automatic waitDone(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      check("busy", {31'd0, bus.busy}, 32'd1);
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] q, input logic [31:0] r,
                             input int expN, input int n);
    check({tag, ".cycles"}, n, expN);
    check({tag, ".done"}, {31'd0, bus.done}, 32'd1);
    check({tag, ".quo"}, bus.quotient, q);
    check({tag, ".rem"}, bus.remainder, r);
  endtask

  task automatic runOp(input string tag, input bit s, input bit u,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r);
    int n;
    applyStimulus(s, u, a, b);
    waitDone(n);
    checkOutput(tag, q, r, 33, n);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.div_start  = 1'b0;
    bus.divu_start = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;

    #12;
    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.done", {31'd0, bus.done}, 32'd0);
    check("rst.quo", bus.quotient, 32'd0);
    check("rst.rem", bus.remainder, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    runOp("u100by7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2);
    @(posedge clk);
    #1;
    check("doneOnce", {31'd0, bus.done}, 32'd0);
    check("idleBusy", {31'd0, bus.busy}, 32'd0);
    check("holdQuo", bus.quotient, 32'd14);
    check("holdRem", bus.remainder, 32'd2);

    runOp("sNeg7by2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    runOp("sMinByM1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    runOp("both7byM1", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd0);
    runOp("u5by0", 1'b0, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    runOp("sNeg5by0", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB);

    // A start during RUN must not disturb the running divide.
    applyStimulus(1'b0, 1'b1, 32'd9, 32'd2);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3);
    waitDone(nCycles);
    checkOutput("ignore", 32'd4, 32'd1, 28, nCycles);

    // A start in the DONE cycle is taken straight away.
    runOp("doneStart", 1'b0, 1'b1, 32'd1000, 32'd10, 32'd100, 32'd0);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      int mode;
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      else if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(16, 30);
      refDiv(mode != 0, a, b, expQ, expR);
      runOp("rand", mode != 0, mode != 1, a, b, expQ, expR);
    end

    // Reset in the middle of RUN aborts immediately.
    runOp("preRst", 1'b0, 1'b1, 32'h1234, 32'h10, 32'h123, 32'h4);
    applyStimulus(1'b0, 1'b1, 32'd50, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
    #1;
    check("abort.busy", {31'd0, bus.busy}, 32'd0);
    check("abort.done", {31'd0, bus.done}, 32'd0);
    check("abort.quo", bus.quotient, 32'd0);
    check("abort.rem", bus.remainder, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    runOp("u10by3", 1'b0, 1'b1, 32'd10, 32'd3, 32'd3, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
